// File: rtl/disp_scan_if.sv
// Bundle of the BCD inputs, display controls and decoder/anode outputs
// exchanged between the clock datapath and the display scan controller.
interface disp_scan_if;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [2:0] blink_sel;
    logic       lz_blank;
    logic [3:0] qh;
    logic [3:0] ql;
    logic [5:0] dig_n;
    logic [1:0] slot;

    // Timekeeping side: supplies digits and display controls.
    modport master (
        output hour, min, sec, blink_sel, lz_blank,
        input  qh, ql, dig_n, slot
    );

    // Scan controller side.
    modport slave (
        input  hour, min, sec, blink_sel, lz_blank,
        output qh, ql, dig_n, slot
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a six-digit HH:MM:SS display.
// One pair of BCD decoders is shared between the hour, minute and second
// digit pairs. Every slot starts with a dark gap to avoid ghosting, the pair
// being set can blink, and a leading zero on the hour tens can be blanked.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int GAP          = 500,
    parameter int BLINK_FRAMES = 167
) (
    input  logic        clk,
    input  logic        rst,
    disp_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [BW-1:0] bcnt;
    logic          bphase;
    logic [3:0]    qh;
    logic [3:0]    ql;
    logic          lat_lz;
    logic [2:0]    lat_blink;
    logic [5:0]    dig_n;

    logic [CW-1:0] cnt_next;
    logic          cnt_wrap;
    logic          latch_now;
    logic          show_next;
    logic [7:0]    sel_pair;
    logic [3:0]    qh_next;
    logic          lz_next;
    logic [2:0]    blink_next;
    logic          blink_bit;
    logic [5:0]    pair_en_n;

    assign cnt_wrap  = (cnt == CW'(SCAN_DIV - 1));
    assign cnt_next  = cnt_wrap ? '0 : cnt + 1'b1;
    assign latch_now = (cnt == '0);
    assign show_next = (cnt_next >= CW'(GAP));

    // Pick the BCD pair belonging to the slot that is about to be latched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        sel_pair = bus.sec;
        case (slot)
            2'd0:    sel_pair = bus.hour;
            2'd1:    sel_pair = bus.min;
            default: sel_pair = bus.sec;
        endcase
    end

    // Latch contents as they will be once the current edge completes; with
    // GAP = 1 the latch edge and the BLANK->SHOW edge coincide.
    always_comb begin
        qh_next    = qh;
        lz_next    = lat_lz;
        blink_next = lat_blink;
        if (latch_now) begin
            qh_next    = sel_pair[7:4];
            lz_next    = bus.lz_blank;
            blink_next = bus.blink_sel;
        end
    end

    // Digit enables for the SHOW part of the current slot, with blink and
    // leading-zero suppression applied.
    always_comb begin
        blink_bit = blink_next[0];
        pair_en_n = 6'b111100;
        case (slot)
            2'd0: begin
                blink_bit = blink_next[2];
                pair_en_n = (lz_next && (qh_next == 4'd0)) ? 6'b101111 : 6'b001111;
            end
            2'd1: begin
                blink_bit = blink_next[1];
                pair_en_n = 6'b110011;
            end
            default: begin
                blink_bit = blink_next[0];
                pair_en_n = 6'b111100;
            end
        endcase
        if (blink_bit && bphase) begin
            pair_en_n = 6'b111111;
        end
    end

    // Slot counter, blink timebase, input latch and BLANK/SHOW FSM with
    // registered digit enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            slot      <= 2'd0;
            bcnt      <= '0;
            bphase    <= 1'b0;
            qh        <= 4'd0;
            ql        <= 4'd0;
            lat_lz    <= 1'b0;
            lat_blink <= 3'd0;
            dig_n     <= 6'b111111;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            cnt <= cnt_next;

            if (cnt_wrap) begin
                if (slot == 2'd2) begin
                    slot <= 2'd0;
                    if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                        bcnt   <= '0;
                        bphase <= ~bphase;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end else begin
                    slot <= slot + 2'd1;
                end
            end

            if (latch_now) begin
                qh        <= sel_pair[7:4];
                ql        <= sel_pair[3:0];
                lat_lz    <= bus.lz_blank;
                lat_blink <= bus.blink_sel;
            end

            case (state)
                ST_BLANK: begin
                    if (show_next) begin
                        state <= ST_SHOW;
                        dig_n <= pair_en_n;
                    end
                end
                ST_SHOW: begin
                    if (!show_next) begin
                        state <= ST_BLANK;
                        dig_n <= 6'b111111;
                    end
                end
            endcase
        end
    end

    assign bus.qh    = qh;
    assign bus.ql    = ql;
    assign bus.dig_n = dig_n;
    assign bus.slot  = slot;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a cycle model pushes expected
// outputs as each cycle's stimulus is applied; a monitor pops and compares
// them on the falling edge.
module tb_disp_scan_ctrl;
    localparam int D  = 8;
    localparam int G  = 2;
    localparam int BF = 2;

    typedef struct {
        logic [3:0] qh;
        logic [3:0] ql;
        logic [5:0] dig_n;
        logic [1:0] slot;
    } exp_t;

    logic clk;
    logic rst;
    disp_scan_if ifc();

    disp_scan_ctrl #(
        .SCAN_DIV    (D),
        .GAP         (G),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Model state: cycle index since reset release and the latched pair.
    int         n;
    logic [3:0] m_qh;
    logic [3:0] m_ql;
    logic       m_lz;
    logic [2:0] m_blink;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp_v, $time);
        end
    endtask

    // Expected outputs for cycle n given the inputs currently applied.
    task automatic push_expected();
        int         c;
        int         s;
        int         f;
        int         bp;
        logic [7:0] pair;
        exp_t       e;
        c = n % D;
        s = (n / D) % 3;
        f = n / (3 * D);
        bp = (f / BF) % 2;
        e.qh = m_qh;
        e.ql = m_ql;
        e.slot = s[1:0];
        if (c == 0) begin
            pair = (s == 0) ? ifc.hour : (s == 1) ? ifc.min : ifc.sec;
            m_qh = pair[7:4];
            m_ql = pair[3:0];
            m_lz = ifc.lz_blank;
            m_blink = ifc.blink_sel;
        end
        if (c < G) begin
            e.dig_n = 6'b111111;
        end else if (m_blink[2 - s] && bp == 1) begin
            e.dig_n = 6'b111111;
        end else if (s == 0) begin
            e.dig_n = (m_lz && m_qh == 4'd0) ? 6'b101111 : 6'b001111;
        end else if (s == 1) begin
            e.dig_n = 6'b110011;
        end else begin
            e.dig_n = 6'b111100;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("qh", 32'(ifc.qh), 32'(e.qh));
            check("ql", 32'(ifc.ql), 32'(e.ql));
            check("dig_n", 32'(ifc.dig_n), 32'(e.dig_n));
            check("slot", 32'(ifc.slot), 32'(e.slot));
        end
    end

    task automatic run(input int k);
        repeat (k) begin
            push_expected();
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        m_qh = 4'd0;
        m_ql = 4'd0;
        m_lz = 1'b0;
        m_blink = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        release_reset();
    endtask

    task automatic set_inputs(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [2:0] bsel, input logic lz);
        ifc.hour = h;
        ifc.min = m;
        ifc.sec = s;
        ifc.blink_sel = bsel;
        ifc.lz_blank = lz;
    endtask

    initial begin
        rst = 1'b1;
        n = 0;
        set_inputs(8'h12, 8'h34, 8'h56, 3'b000, 1'b0);
        #1;
        check("rst_dig_n", 32'(ifc.dig_n), 32'h3f);
        check("rst_qh", 32'(ifc.qh), 32'h0);
        check("rst_slot", 32'(ifc.slot), 32'h0);
        release_reset();

        // Plain scan order, gap and repeat over two frames.
        run(48);

        // Asynchronous reset at cnt = 5 of slot 1.
        do_reset();
        run(13);
        #1;
        rst = 1'b1;
        #1;
        check("async_dig_n", 32'(ifc.dig_n), 32'h3f);
        check("async_qh", 32'(ifc.qh), 32'h0);
        check("async_ql", 32'(ifc.ql), 32'h0);
        check("async_slot", 32'(ifc.slot), 32'h0);
        release_reset();
        run(24);

        // Leading-zero blanking of the hour tens.
        set_inputs(8'h07, 8'h34, 8'h56, 3'b000, 1'b1);
        do_reset();
        run(24);
        ifc.lz_blank = 1'b0;
        run(24);
        ifc.hour = 8'h17;
        ifc.lz_blank = 1'b1;
        run(24);

        // Minute pair blinking over two full blink periods.
        set_inputs(8'h12, 8'h34, 8'h56, 3'b010, 1'b0);
        do_reset();
        run(192);

        // Minute change inside the minute slot.
        set_inputs(8'h12, 8'h34, 8'h56, 3'b000, 1'b0);
        do_reset();
        run(12);
        ifc.min = 8'h59;
        run(29);

        // Hex nibbles pass through unchanged.
        set_inputs(8'hAB, 8'hCD, 8'hEF, 3'b000, 1'b0);
        do_reset();
        run(24);

        @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing scan controller that shares one pair of BCD-to-7-segment decoders among the three digit pairs of the clock: hours, minutes and seconds. Each cycle it selects one BCD pair, presents it on `qh`/`ql` to the decoder pair, and drives six active-low digit enables. It also inserts an anti-ghosting blank gap at the start of every slot, blinks the pair being set, and optionally blanks a leading zero in the hour tens digit. It sits between the timekeeping counters and the decoder/anode pins.

## Interface
- `SCAN_DIV`, default 50000: clocks per slot (1 ms at 50 MHz). Must be ≥ 2.
- `GAP`, default 500: blank clocks at the start of each slot. Range 1 ≤ GAP < SCAN_DIV.
- `BLINK_FRAMES`, default 167: frames per blink half-period. One frame is 3 slots. Must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `hour`  in  8  BCD: [7:4] tens, [3:0] units.
- `min`  in  8  BCD minutes, same packing.
- `sec`  in  8  BCD seconds, same packing.
- `blink_sel`  in  3  one-hot blink enable: bit2 hour, bit1 min, bit0 sec.
- `lz_blank`  in  1  1 = blank the hour tens digit when it is 0.
- `qh`  out  4  tens digit to the high decoder.
- `ql`  out  4  units digit to the low decoder.
- `dig_n`  out  6  active-low digit enables. Bit order [5:0] = hour tens, hour units, min tens, min units, sec tens, sec units.
- `slot`  out  2  current slot: 0 hour, 1 min, 2 sec.

## Operation
- Internal state:
  - `cnt`: 0..SCAN_DIV-1.
  - `slot`: 0..2.
  - `bcnt`: 0..BLINK_FRAMES-1.
  - `bphase`: 1 bit.
  - Latch registers for the current pair, `lz_blank` and `blink_sel`.
- `cnt` increments every clock. On reaching SCAN_DIV-1 it wraps to 0, and `slot` advances 0→1→2→0.
- Frame wrap is `slot` 2→0. On each frame wrap `bcnt` increments. When `bcnt` is BLINK_FRAMES-1 at a frame wrap, `bcnt`→0 and `bphase` toggles.
- Per-slot FSM, decoded from `cnt`:
  - BLANK while `cnt` < GAP. All `dig_n` = 1.
  - SHOW while `cnt` ≥ GAP. The current pair's two enable bits are driven low unless suppressed.
- Input latch:
  - At the rising edge ending the cycle with `cnt` == 0, the slot's pair, `lz_blank` and `blink_sel` are latched.
  - `qh`/`ql` come from the latch and are constant from `cnt` = 1 to the end of the slot.
  - Input changes inside a slot are not visible until that slot next comes round.
  - Because GAP ≥ 1, stale data is never shown.
- Suppression applies during SHOW only; `qh`/`ql` are still driven normally:
  - Blink: if the latched `blink_sel` bit for the current slot is 1 and `bphase` = 1, both enables of the pair stay 1.
  - Leading zero: in slot 0, if latched `lz_blank` = 1 and latched tens = 0, `dig_n[5]` stays 1. `dig_n[4]` is unaffected.
- Invalid BCD nibbles (A–F) are passed through unchanged; the decoder displays them as hex.
- Reset values:
  - `cnt` = 0, `slot` = 0, `bcnt` = 0, `bphase` = 0.
  - `qh` = 0, `ql` = 0.
  - `dig_n` = 6'b111111.
  - Reset asserted mid-slot takes effect immediately, without waiting for a clock edge.

## Timing
- Let cycle n = 0 be the first clock cycle after `rst` deasserts.
  - `cnt` = n mod SCAN_DIV.
  - `slot` = (n div SCAN_DIV) mod 3.
  - Frame index f = n div (3·SCAN_DIV).
  - `bphase` = (f div BLINK_FRAMES) mod 2.
- Each slot lasts exactly SCAN_DIV cycles: GAP cycles dark, then SCAN_DIV−GAP cycles lit.
- `qh`/`ql` take the new slot's value from cycle `cnt` = 1 of that slot. During `cnt` = 0 they still hold the previous slot's value (0 after reset).
- `dig_n` and `slot` change only when `cnt` moves to 0 or to GAP.
- No glitches: `dig_n` is registered or decoded only from registered state.

## Test plan
All scenarios use SCAN_DIV = 8, GAP = 2, BLINK_FRAMES = 2, with `hour` = 8'h12, `min` = 8'h34, `sec` = 8'h56 unless stated.
- Reset: pulse `rst` high at `cnt` = 5 of slot 1 → immediately `dig_n` = 111111, `qh` = `ql` = 0, `slot` = 0. After release, `cnt` restarts at 0.
- Scan order, `blink_sel` = 0, `lz_blank` = 0:
  - Cycles 2–7: `qh`/`ql` = 1/2, `dig_n` = 001111.
  - Cycles 10–15: 3/4, `dig_n` = 110011.
  - Cycles 18–23: 5/6, `dig_n` = 111100.
  - Pattern repeats every 24 cycles.
- Gap: `dig_n` = 111111 at every cycle with n mod 8 ∈ {0,1}. `qh` changes only at n mod 8 = 1.
- Leading zero, `hour` = 8'h07:
  - `lz_blank` = 1 → hour SHOW `dig_n` = 101111.
  - `lz_blank` = 0 → 001111.
  - `hour` = 8'h17 with `lz_blank` = 1 → 001111.
- Blink, `blink_sel` = 3'b010: min-slot `dig_n` = 110011 in frames 0–1, 111111 in frames 2–3, and the pattern repeats with a 96-cycle period. Hour and sec slots are unaffected.
- Mid-slot change: set `min` = 8'h59 at n = 12 → `qh`/`ql` stay 3/4 through n = 15 and show 5/9 from n = 33.
